hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline sequencer for the 5-stage datapath. Decides, every cycle, which latch advances, freezes or is flushed: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Covers load-use stalls that forwarding cannot resolve, dcache miss freezes, icache miss bubbles, taken-branch/jump squashes and halt.
- Sits beside forwarding_unit and consumes the same stage register/write-enable fields through discrete ports.

Parameters:
- LOADUSE_BUBBLES, 1, bubbles inserted per load-use hazard (1..7).
- STALL_CNT_W, 32, counter width for the optional performance counters.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- ihit  input  1  instruction fetch complete this cycle.
- dhit  input  1  data access complete this cycle.
- dmemREN_mem  input  1  load in MEM stage.
- dmemWEN_mem  input  1  store in MEM stage.
- memread_ex  input  1  instruction in EX is a load.
- regOut_ex  input  5  destination register of EX instruction.
- Rs_id  input  5  rs of ID instruction.
- Rt_id  input  5  rt of ID instruction.
- rt_used_id  input  1  ID instruction reads rt as a source.
- branch_taken_mem  input  1  branch/jump resolved taken in MEM.
- halt_wb  input  1  halt instruction reached WB.
- pc_en  output  1  PC update enable.
- ifid_en, idex_en, exmem_en, memwb_en  output  1 each  latch enables.
- ifid_flush, idex_flush, exmem_flush  output  1 each  load bubble (nop, all write enables 0).
- halt  output  1  sticky halted flag.

Behaviour:
- State (hazard_state_t): RUN, LDUSE, MEMWAIT, HALTED. Bubble counter bcnt is 3 bits.
- Reset: state=RUN, bcnt=0. While nRST is low all outputs are forced to 0. Reset asserted mid-stall or mid-miss aborts it immediately.
- Outputs are combinational from state and inputs. Default: all enables=1, all flushes=0, halt=0.
- Priority in RUN and LDUSE, highest first:
  - (1) halt_wb: all enables=0 from the same cycle; next state HALTED.
  - (2) (dmemREN_mem|dmemWEN_mem) & !dhit: all enables=0; next state MEMWAIT. bcnt is held.
  - (3) branch_taken_mem: pc_en=1, ifid_flush=idex_flush=exmem_flush=1; bcnt:=0; next state RUN. A pending load-use on a squashed instruction is dropped.
  - (4) Load-use hazard: condition is memread_ex & regOut_ex!=0 & (Rs_id==regOut_ex | (rt_used_id & Rt_id==regOut_ex)). Response: pc_en=0, ifid_en=0, idex_flush=1. If LOADUSE_BUBBLES>1, bcnt:=LOADUSE_BUBBLES-1 and next state LDUSE.
  - (5) !ihit: pc_en=0, ifid_flush=1; downstream latches advance.
- LDUSE: repeats the load-use response while bcnt!=0, decrementing bcnt each cycle. At bcnt==1 the next state is RUN. Priorities (1)-(3) preempt it.
- MEMWAIT: all enables=0 until dhit. On the dhit cycle all enables=1, the memory result latches into MEM/WB, and next state is RUN (LDUSE if bcnt!=0). halt_wb cannot occur here because WB is frozen.
- HALTED: all enables=0, flushes=0, halt=1. Exit only by reset.
- An enable and a flush never both deassert work on the same latch: flush implies enable=1 for that latch.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds output ports stall_cycles, flush_events, miss_cycles (STALL_CNT_W each).
  - stall_cycles counts cycles with pc_en=0.
  - flush_events counts branch squashes.
  - miss_cycles counts cycles spent in MEMWAIT.
  - All counters saturate, clear on reset, and freeze in HALTED.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- cpu_types_pkg: hazard_state_t enum (2 bits) and a bubble-count localparam width.
- regbits_t (5-bit register index) is reused from cpu_types_pkg.
- Sub-module hazard_perf_counters holds the three saturating counters; it is instantiated only under HAZARD_PERF_EN.

Test Plan:
- Load-use: `lw $3` in EX, ID reads `$3` via Rs_id=3, ihit=dhit=1 → one cycle with pc_en=0, ifid_en=0, idex_flush=1, then normal. Repeat with regOut_ex=0 → no stall.
- LOADUSE_BUBBLES=3 with the same stimulus → exactly 3 consecutive bubble cycles. branch_taken_mem in the 2nd cycle → triple flush that cycle, back to RUN, no third bubble.
- dmemREN_mem=1, dhit low for 4 cycles then high → 4 cycles with all enables 0, 5th cycle all enables 1, then RUN.
- branch_taken_mem=1 with ihit=0 in the same cycle → pc_en=1 and three flushes; ifid_flush is from the branch, not the miss.
- halt_wb=1 → halt=1 from the next cycle and stays set through random ihit/dhit. Pulse nRST low mid-MEMWAIT → outputs 0 asynchronously, then RUN.
- With HAZARD_PERF_EN: 2 load-use stalls + 1 branch + 4-cycle dcache miss → stall_cycles=6 (2 bubbles + 4 miss), flush_events=1, miss_cycles=4.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types for the pipeline control blocks
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDUSE   = 2'd1,
    MEMWAIT = 2'd2,
    HALTED  = 2'd3
  } hazard_state_t;

  localparam int BCNT_W = 3;

endpackage

// File: rtl/hazard_perf_counters.sv
// rtl/hazard_perf_counters.sv - saturating stall/flush/miss counters for hazard_controller
module hazard_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             stall_inc,
  input  logic             flush_inc,
  input  logic             miss_inc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] miss_cycles
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
      miss_cycles  <= '0;
    end else if (!freeze) begin
      stall_cycles <= sat_inc(stall_cycles, stall_inc);
      flush_events <= sat_inc(flush_events, flush_inc);
      miss_cycles  <= sat_inc(miss_cycles, miss_inc);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - 5-stage pipeline stall/flush/halt sequencer
// HAZARD_PERF_EN adds saturating stall/flush/miss performance counters.
module hazard_controller
  import cpu_types_pkg::*;
#(
  parameter int LOADUSE_BUBBLES = 1
`ifdef HAZARD_PERF_EN
  , parameter int STALL_CNT_W = 32
`endif
) (
  input  logic     CLK,
  input  logic     nRST,
  input  logic     ihit,
  input  logic     dhit,
  input  logic     dmemREN_mem,
  input  logic     dmemWEN_mem,
  input  logic     memread_ex,
  input  regbits_t regOut_ex,
  input  regbits_t Rs_id,
  input  regbits_t Rt_id,
  input  logic     rt_used_id,
  input  logic     branch_taken_mem,
  input  logic     halt_wb,
  output logic     pc_en,
  output logic     ifid_en,
  output logic     idex_en,
  output logic     exmem_en,
  output logic     memwb_en,
  output logic     ifid_flush,
  output logic     idex_flush,
  output logic     exmem_flush,
  output logic     halt
`ifdef HAZARD_PERF_EN
  , output logic [STALL_CNT_W-1:0] stall_cycles
  , output logic [STALL_CNT_W-1:0] flush_events
  , output logic [STALL_CNT_W-1:0] miss_cycles
`endif
);

  hazard_state_t     state, state_nxt;
  logic [BCNT_W-1:0] bcnt, bcnt_nxt;
  logic              loaduse_hit, lu_pending, dmiss;

  assign loaduse_hit = memread_ex && (regOut_ex != '0) &&
                       ((Rs_id == regOut_ex) || (rt_used_id && (Rt_id == regOut_ex)));
  assign lu_pending  = (state == LDUSE) && (bcnt != '0);
  assign dmiss       = (dmemREN_mem || dmemWEN_mem) && !dhit;

  always_comb begin
    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
    {ifid_flush, idex_flush, exmem_flush}         = 3'b000;
    halt      = 1'b0;
    state_nxt = state;
    bcnt_nxt  = bcnt;
    unique case (state)
      RUN, LDUSE: begin
        state_nxt = RUN;
        if (halt_wb) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
          state_nxt = HALTED;
        end else if (dmiss) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
          state_nxt = MEMWAIT;
        end else if (branch_taken_mem) begin
          // Squash drops any bubbles still owed to the killed instruction.
          {ifid_flush, idex_flush, exmem_flush} = 3'b111;
          bcnt_nxt = '0;
        end else if (lu_pending || loaduse_hit) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          if (lu_pending) begin
            bcnt_nxt  = bcnt - BCNT_W'(1);
            state_nxt = (bcnt == BCNT_W'(1)) ? RUN : LDUSE;
          end else if (LOADUSE_BUBBLES > 1) begin
            bcnt_nxt  = BCNT_W'(LOADUSE_BUBBLES - 1);
            state_nxt = LDUSE;
          end
        end else if (!ihit) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
      end
      MEMWAIT: begin
        if (!dhit) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
        end else begin
          state_nxt = (bcnt != '0) ? LDUSE : RUN;
        end
      end
      HALTED: begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
        halt = 1'b1;
      end
    endcase
    if (!nRST) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      {ifid_flush, idex_flush, exmem_flush}         = 3'b000;
      halt = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  // Only a branch squash flushes EX/MEM, so that flush doubles as the event strobe.
  hazard_perf_counters #(
    .CNT_W(STALL_CNT_W)
  ) u_perf (
    .clk         (CLK),
    .rst_n       (nRST),
    .freeze      (state == HALTED),
    .stall_inc   (!pc_en),
    .flush_inc   (exmem_flush),
    .miss_inc    (state == MEMWAIT),
    .stall_cycles(stall_cycles),
    .flush_events(flush_events),
    .miss_cycles (miss_cycles)
  );
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       ihit, dhit, dmemREN_mem, dmemWEN_mem, memread_ex, rt_used_id;
  logic       branch_taken_mem, halt_wb;
  logic [4:0] regOut_ex, Rs_id, Rt_id;

  logic a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifid_f, a_idex_f, a_exmem_f, a_halt;
  logic b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ifid_f, b_idex_f, b_exmem_f, b_halt;
  logic [8:0] a_vec, b_vec;

  int n_checks = 0;
  int n_fail   = 0;

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, exmem_flush, halt}
  localparam logic [8:0] NORM  = 9'b11111_000_0;
  localparam logic [8:0] FRZ   = 9'b00000_000_0;
  localparam logic [8:0] LU    = 9'b00111_010_0;
  localparam logic [8:0] IMISS = 9'b01111_100_0;
  localparam logic [8:0] BR    = 9'b11111_111_0;
  localparam logic [8:0] HLT   = 9'b00000_000_1;

  assign a_vec = {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifid_f, a_idex_f, a_exmem_f, a_halt};
  assign b_vec = {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ifid_f, b_idex_f, b_exmem_f, b_halt};

`ifdef HAZARD_PERF_EN
  logic [31:0] a_stall, a_flush, a_miss, b_stall, b_flush, b_miss;
`endif

  always #5 CLK = ~CLK;

  hazard_controller #(.LOADUSE_BUBBLES(1)) u_dut1 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem), .memread_ex(memread_ex),
    .regOut_ex(regOut_ex), .Rs_id(Rs_id), .Rt_id(Rt_id), .rt_used_id(rt_used_id),
    .branch_taken_mem(branch_taken_mem), .halt_wb(halt_wb),
    .pc_en(a_pc), .ifid_en(a_ifid), .idex_en(a_idex), .exmem_en(a_exmem), .memwb_en(a_memwb),
    .ifid_flush(a_ifid_f), .idex_flush(a_idex_f), .exmem_flush(a_exmem_f), .halt(a_halt)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(a_stall), .flush_events(a_flush), .miss_cycles(a_miss)
`endif
  );

  hazard_controller #(.LOADUSE_BUBBLES(3)) u_dut3 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem), .memread_ex(memread_ex),
    .regOut_ex(regOut_ex), .Rs_id(Rs_id), .Rt_id(Rt_id), .rt_used_id(rt_used_id),
    .branch_taken_mem(branch_taken_mem), .halt_wb(halt_wb),
    .pc_en(b_pc), .ifid_en(b_ifid), .idex_en(b_idex), .exmem_en(b_exmem), .memwb_en(b_memwb),
    .ifid_flush(b_ifid_f), .idex_flush(b_idex_f), .exmem_flush(b_exmem_f), .halt(b_halt)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(b_stall), .flush_events(b_flush), .miss_cycles(b_miss)
`endif
  );

  task automatic idle();
    ihit = 1'b1; dhit = 1'b1; dmemREN_mem = 1'b0; dmemWEN_mem = 1'b0;
    memread_ex = 1'b0; rt_used_id = 1'b0; branch_taken_mem = 1'b0; halt_wb = 1'b0;
    regOut_ex = 5'd0; Rs_id = 5'd0; Rt_id = 5'd0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_lu();
    memread_ex = 1'b1; regOut_ex = 5'd3; Rs_id = 5'd3; Rt_id = 5'd7; rt_used_id = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    branch_taken_mem = 1'b1;
    #3;
    n_checks++; if (a_vec !== 9'd0) begin n_fail++; $display("FAIL reset_a got %b exp %b", a_vec, 9'd0); end
    n_checks++; if (b_vec !== 9'd0) begin n_fail++; $display("FAIL reset_b got %b exp %b", b_vec, 9'd0); end
    tick();
    idle();
    nRST = 1'b1;
    #2;
    n_checks++; if (a_vec !== NORM) begin n_fail++; $display("FAIL reset_exit_a got %b exp %b", a_vec, NORM); end
    n_checks++; if (b_vec !== NORM) begin n_fail++; $display("FAIL reset_exit_b got %b exp %b", b_vec, NORM); end
  endtask

  task automatic test_loaduse_match();
    tick();
    idle();
    Rs_id = 5'd3; Rt_id = 5'd5; regOut_ex = 5'd5; memread_ex = 1'b1; rt_used_id = 1'b1;
    #2;
    n_checks++; if (a_vec !== LU) begin n_fail++; $display("FAIL lu_rt_a got %b exp %b", a_vec, LU); end
    rt_used_id = 1'b0;
    #1;
    n_checks++; if (a_vec !== NORM) begin n_fail++; $display("FAIL lu_rt_unused_a got %b exp %b", a_vec, NORM); end
    regOut_ex = 5'd0; Rs_id = 5'd0;
    #1;
    n_checks++; if (b_vec !== NORM) begin n_fail++; $display("FAIL lu_r0_b got %b exp %b", b_vec, NORM); end
    idle();
  endtask

  task automatic test_loaduse_bubbles();
    tick();
    set_lu();
    #2;
    n_checks++; if (a_vec !== LU) begin n_fail++; $display("FAIL lu1_c0 got %b exp %b", a_vec, LU); end
    n_checks++; if (b_vec !== LU) begin n_fail++; $display("FAIL lu3_c0 got %b exp %b", b_vec, LU); end
    tick();
    memread_ex = 1'b0;
    #2;
    n_checks++; if (a_vec !== NORM) begin n_fail++; $display("FAIL lu1_c1 got %b exp %b", a_vec, NORM); end
    n_checks++; if (b_vec !== LU) begin n_fail++; $display("FAIL lu3_c1 got %b exp %b", b_vec, LU); end
    tick();
    #2;
    n_checks++; if (b_vec !== LU) begin n_fail++; $display("FAIL lu3_c2 got %b exp %b", b_vec, LU); end
    tick();
    #2;
    n_checks++; if (b_vec !== NORM) begin n_fail++; $display("FAIL lu3_c3 got %b exp %b", b_vec, NORM); end
    idle();
  endtask

  task automatic test_branch_preempt();
    tick();
    set_lu();
    #2;
    tick();
    memread_ex = 1'b0; branch_taken_mem = 1'b1;
    #2;
    n_checks++; if (a_vec !== BR) begin n_fail++; $display("FAIL brpre_a got %b exp %b", a_vec, BR); end
    n_checks++; if (b_vec !== BR) begin n_fail++; $display("FAIL brpre_b got %b exp %b", b_vec, BR); end
    tick();
    branch_taken_mem = 1'b0;
    #2;
    n_checks++; if (b_vec !== NORM) begin n_fail++; $display("FAIL brpre_nobubble_b got %b exp %b", b_vec, NORM); end
    idle();
  endtask

  task automatic test_dmiss();
    tick();
    dmemREN_mem = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_checks++; if (a_vec !== FRZ) begin n_fail++; $display("FAIL dmiss_frz%0d_a got %b exp %b", i, a_vec, FRZ); end
      tick();
    end
    dhit = 1'b1;
    #2;
    n_checks++; if (a_vec !== NORM) begin n_fail++; $display("FAIL dmiss_hit_a got %b exp %b", a_vec, NORM); end
    n_checks++; if (b_vec !== NORM) begin n_fail++; $display("FAIL dmiss_hit_b got %b exp %b", b_vec, NORM); end
    tick();
    dmemREN_mem = 1'b0; ihit = 1'b0;
    #2;
    n_checks++; if (a_vec !== IMISS) begin n_fail++; $display("FAIL dmiss_after_a got %b exp %b", a_vec, IMISS); end
    idle();
  endtask

  task automatic test_miss_in_lduse();
    tick();
    set_lu();
    #2;
    tick();
    memread_ex = 1'b0; dmemWEN_mem = 1'b1; dhit = 1'b0;
    #2;
    n_checks++; if (b_vec !== FRZ) begin n_fail++; $display("FAIL ldmiss_frz_b got %b exp %b", b_vec, FRZ); end
    tick();
    dhit = 1'b1;
    #2;
    n_checks++; if (b_vec !== NORM) begin n_fail++; $display("FAIL ldmiss_hit_b got %b exp %b", b_vec, NORM); end
    tick();
    dmemWEN_mem = 1'b0;
    #2;
    n_checks++; if (a_vec !== NORM) begin n_fail++; $display("FAIL ldmiss_resume_a got %b exp %b", a_vec, NORM); end
    n_checks++; if (b_vec !== LU) begin n_fail++; $display("FAIL ldmiss_resume1_b got %b exp %b", b_vec, LU); end
    tick();
    #2;
    n_checks++; if (b_vec !== LU) begin n_fail++; $display("FAIL ldmiss_resume2_b got %b exp %b", b_vec, LU); end
    tick();
    #2;
    n_checks++; if (b_vec !== NORM) begin n_fail++; $display("FAIL ldmiss_done_b got %b exp %b", b_vec, NORM); end
    idle();
  endtask

  task automatic test_branch_imiss();
    tick();
    ihit = 1'b0; branch_taken_mem = 1'b1;
    #2;
    n_checks++; if (a_vec !== BR) begin n_fail++; $display("FAIL br_imiss_a got %b exp %b", a_vec, BR); end
    tick();
    branch_taken_mem = 1'b0;
    #2;
    n_checks++; if (b_vec !== IMISS) begin n_fail++; $display("FAIL imiss_b got %b exp %b", b_vec, IMISS); end
    idle();
  endtask

  task automatic test_halt();
    tick();
    halt_wb = 1'b1;
    #2;
    n_checks++; if (a_vec !== FRZ) begin n_fail++; $display("FAIL halt_c0_a got %b exp %b", a_vec, FRZ); end
    tick();
    halt_wb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ihit = 1'($urandom_range(0, 1)); dhit = 1'($urandom_range(0, 1));
      dmemREN_mem = 1'($urandom_range(0, 1)); branch_taken_mem = 1'($urandom_range(0, 1));
      #2;
      n_checks++; if (a_vec !== HLT) begin n_fail++; $display("FAIL halt_sticky%0d_a got %b exp %b", i, a_vec, HLT); end
      n_checks++; if (b_vec !== HLT) begin n_fail++; $display("FAIL halt_sticky%0d_b got %b exp %b", i, b_vec, HLT); end
      tick();
    end
    #2;
    nRST = 1'b0;
    #1;
    n_checks++; if (a_vec !== 9'd0) begin n_fail++; $display("FAIL halt_async_rst_a got %b exp %b", a_vec, 9'd0); end
    idle();
    nRST = 1'b1;
    #1;
    n_checks++; if (a_vec !== NORM) begin n_fail++; $display("FAIL halt_exit_a got %b exp %b", a_vec, NORM); end
  endtask

  task automatic test_reset_midmiss();
    tick();
    dmemREN_mem = 1'b1; dhit = 1'b0;
    tick();
    #2;
    n_checks++; if (b_vec !== FRZ) begin n_fail++; $display("FAIL midmiss_frz_b got %b exp %b", b_vec, FRZ); end
    tick();
    dmemREN_mem = 1'b0; ihit = 1'b0; branch_taken_mem = 1'b1;
    nRST = 1'b0;
    #2;
    n_checks++; if (a_vec !== 9'd0) begin n_fail++; $display("FAIL midmiss_rst_a got %b exp %b", a_vec, 9'd0); end
    branch_taken_mem = 1'b0;
    nRST = 1'b1;
    #1;
    n_checks++; if (a_vec !== IMISS) begin n_fail++; $display("FAIL midmiss_run_a got %b exp %b", a_vec, IMISS); end
    n_checks++; if (b_vec !== IMISS) begin n_fail++; $display("FAIL midmiss_run_b got %b exp %b", b_vec, IMISS); end
    idle();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    tick();
    nRST = 1'b0;
    #1;
    nRST = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      set_lu();
      tick();
      memread_ex = 1'b0;
      tick();
      tick();
    end
    tick();
    branch_taken_mem = 1'b1;
    tick();
    branch_taken_mem = 1'b0; dmemREN_mem = 1'b1; dhit = 1'b0;
    repeat (4) tick();
    dhit = 1'b1;
    tick();
    idle();
    #2;
    n_checks++; if (a_stall !== 32'd6)  begin n_fail++; $display("FAIL perf_stall_a got %0d exp %0d", a_stall, 6); end
    n_checks++; if (a_flush !== 32'd1)  begin n_fail++; $display("FAIL perf_flush_a got %0d exp %0d", a_flush, 1); end
    n_checks++; if (a_miss  !== 32'd4)  begin n_fail++; $display("FAIL perf_miss_a got %0d exp %0d", a_miss, 4); end
    n_checks++; if (b_stall !== 32'd10) begin n_fail++; $display("FAIL perf_stall_b got %0d exp %0d", b_stall, 10); end
    tick();
    halt_wb = 1'b1;
    tick();
    halt_wb = 1'b0; ihit = 1'b0;
    repeat (3) tick();
    #2;
    n_checks++; if (a_stall !== 32'd7) begin n_fail++; $display("FAIL perf_halt_freeze_a got %0d exp %0d", a_stall, 7); end
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_loaduse_match();
    test_loaduse_bubbles();
    test_branch_preempt();
    test_dmiss();
    test_miss_in_lduse();
    test_branch_imiss();
    test_halt();
    test_reset_midmiss();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
